// File: rtl/imem_fetch_responder_if.sv
// Fetch request/response bus between the core fetch port (master) and
// imem_fetch_responder (slave). Valid/ready handshakes on both directions.
interface imem_fetch_responder_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int INST_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [INST_WIDTH-1:0] resp_inst;
  logic                  resp_err;

  modport master (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_inst, resp_err
  );

  modport slave (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_inst, resp_err
  );
endinterface

// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: fixed-latency read pipeline, in-order response FIFO, credit flow control.
// Optional feature macro IMEM_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
module imem_fetch_responder #(
  parameter int                    ADDR_WIDTH  = 64,
  parameter int                    INST_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 64'h8000_0000,
  parameter int                    LATENCY     = 2,
  parameter int                    QDEPTH      = 4,
  localparam int                   IDX_WIDTH   = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  imem_fetch_responder_if.slave bus,
  input  logic                  load_en,
  input  logic [IDX_WIDTH-1:0]  load_idx,
  input  logic [INST_WIDTH-1:0] load_data
`ifdef IMEM_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);

  localparam int PTR_WIDTH = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_WIDTH = $clog2(QDEPTH + 1);
  localparam logic [CNT_WIDTH-1:0]    QDEPTH_C = CNT_WIDTH'(QDEPTH);
  localparam logic [PTR_WIDTH-1:0]    PTR_LAST = PTR_WIDTH'(QDEPTH - 1);
  localparam logic [ADDR_WIDTH-3:0]   DEPTH_C  = (ADDR_WIDTH-2)'(DEPTH_WORDS);

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  logic [INST_WIDTH-1:0] storage_q [DEPTH_WORDS];

  logic                  ready_en_q, ready_en_d;
  logic [CNT_WIDTH-1:0]  credit_q, credit_d;

  logic [LATENCY-1:0]    pipe_valid_q, pipe_valid_d;
  logic [INST_WIDTH-1:0] pipe_inst_q [LATENCY];
  logic [INST_WIDTH-1:0] pipe_inst_d [LATENCY];
  logic [LATENCY-1:0]    pipe_err_q, pipe_err_d;

  logic [INST_WIDTH-1:0] fifo_inst_q [QDEPTH];
  logic [INST_WIDTH-1:0] fifo_inst_d [QDEPTH];
  logic [QDEPTH-1:0]     fifo_err_q, fifo_err_d;
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  logic [ADDR_WIDTH-3:0] off_word;
  logic [IDX_WIDTH-1:0]  dec_idx;
  logic                  dec_err;
  logic [INST_WIDTH-1:0] dec_inst;

  logic                  req_ready;
  logic                  resp_valid;
  logic                  accept;
  logic                  push;
  logic                  pop;

  // Storage is not reset; a load lands at the edge, so a same-edge fetch still sees the old word.
  always_ff @(posedge clk) begin
    if (load_en) begin
      storage_q[load_idx] <= load_data;
    end
  end

  // BASE_ADDR is word aligned, so the word offset needs only the upper address bits.
  always_comb begin
    off_word = bus.req_addr[ADDR_WIDTH-1:2] - BASE_ADDR[ADDR_WIDTH-1:2];
    dec_idx  = off_word[IDX_WIDTH-1:0];
    dec_err  = (bus.req_addr[1:0] != 2'b00) ||
               (bus.req_addr < BASE_ADDR) ||
               (off_word >= DEPTH_C);
    dec_inst = dec_err ? '0 : storage_q[dec_idx];
  end

  always_comb begin
    req_ready  = ready_en_q && (credit_q < QDEPTH_C);
    resp_valid = (count_q != '0);
    accept     = bus.req_valid && req_ready;
    push       = pipe_valid_q[LATENCY-1];
    pop        = resp_valid && bus.resp_ready;
  end

  // credit covers requests in the pipeline plus buffered responses, so the FIFO can never overflow.
  always_comb begin
    ready_en_d = 1'b1;
    case ({accept, pop})
      2'b10:   credit_d = credit_q + CNT_WIDTH'(1);
      2'b01:   credit_d = credit_q - CNT_WIDTH'(1);
      default: credit_d = credit_q;
    endcase
  end

  always_comb begin
    pipe_valid_d    = '0;
    pipe_err_d      = '0;
    pipe_inst_d     = pipe_inst_q;
    pipe_valid_d[0] = accept;
    pipe_inst_d[0]  = dec_inst;
    pipe_err_d[0]   = dec_err;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_valid_d[i] = pipe_valid_q[i-1];
      pipe_inst_d[i]  = pipe_inst_q[i-1];
      pipe_err_d[i]   = pipe_err_q[i-1];
    end
  end

  always_comb begin
    fifo_inst_d = fifo_inst_q;
    fifo_err_d  = fifo_err_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) begin
      fifo_inst_d[wr_ptr_q] = pipe_inst_q[LATENCY-1];
      fifo_err_d[wr_ptr_q]  = pipe_err_q[LATENCY-1];
      wr_ptr_d              = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en_q   <= 1'b0;
      credit_q     <= '0;
      pipe_valid_q <= '0;
      pipe_inst_q  <= '{default: '0};
      pipe_err_q   <= '0;
      fifo_inst_q  <= '{default: '0};
      fifo_err_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      ready_en_q   <= ready_en_d;
      credit_q     <= credit_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_inst_q  <= pipe_inst_d;
      pipe_err_q   <= pipe_err_d;
      fifo_inst_q  <= fifo_inst_d;
      fifo_err_q   <= fifo_err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Response data is forced to zero whenever nothing is being presented.
  always_comb begin
    bus.req_ready  = req_ready;
    bus.resp_valid = resp_valid;
    bus.resp_inst  = resp_valid ? fifo_inst_q[rd_ptr_q] : '0;
    bus.resp_err   = resp_valid && fifo_err_q[rd_ptr_q];
  end

  fifo_no_overflow: assert property (
    @(posedge clk) disable iff (rst) !(push && (count_q == QDEPTH_C))
  );

`ifdef IMEM_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q + (accept ? 32'd1 : 32'd0);
    perf_stall_d = perf_stall_q + ((bus.req_valid && !req_ready) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
